// File: rtl/inst_fetch_resp.sv
// inst_fetch_resp
// Instruction-side responder for the IFU fetch interface. Keeps one line of
// LINE_WORDS instruction words. A hit returns its word in the same cycle. A
// miss raises stall_req_o and refills the line one word at a time from the
// backing memory over a req/ack handshake.
//
// Ports
//   clk_i, rst_i      clock; synchronous active-high reset
//   pc_i, ce_i        fetch address and fetch enable from the IFU
//   flush_i           abort a refill in progress (pipeline redirect)
//   inst_o            instruction word, NOP_INST when not valid
//   inst_valid_o      inst_o is valid for the current pc_i
//   misaligned_o      enabled fetch with pc_i[1:0] != 0
//   stall_req_o       IFU must hold pc_i
//   mem_req_o         backing-memory word read request
//   mem_addr_o        word-aligned read address
//   mem_ack_i         mem_rdata_i valid, completes the current request
//   mem_rdata_i       read data
//
// state   | meaning
// S_IDLE  | line usable for hits; a stalled fetch starts a refill
// S_FILL  | refilling the line, one word per ack
// S_ABORT | flushed mid-word; waiting for the owed ack, data discarded
module inst_fetch_resp #(
    parameter int unsigned LINE_WORDS = 4,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_i,
    input  logic        ce_i,
    input  logic        flush_i,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        misaligned_o,
    output logic        stall_req_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned IDX_W = $clog2(LINE_WORDS);
    localparam int unsigned OFF   = IDX_W + 2;
    localparam int unsigned TAG_W = 32 - OFF;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_ABORT
    } state_t;

    state_t           state_q;
    logic [31:0]      line_q [LINE_WORDS];
    logic [TAG_W-1:0] tag_q;
    logic [TAG_W-1:0] fill_tag_q;
    logic [IDX_W-1:0] cnt_q;
    logic             line_valid_q;

    logic             aligned;
    logic             hit;
    logic [IDX_W-1:0] word_idx;

    assign aligned  = (pc_i[1:0] == 2'b00);
    assign word_idx = pc_i[OFF-1:2];
    assign hit      = ce_i && aligned && line_valid_q
                      && (pc_i[31:OFF] == tag_q) && (state_q == S_IDLE);

    assign inst_valid_o = hit;
    assign inst_o       = hit ? line_q[word_idx] : NOP_INST;
    assign misaligned_o = ce_i && !aligned;
    assign stall_req_o  = ce_i && aligned && !hit && !flush_i;

    // The fill address is built by concatenation, so it can never carry out
    // of the line (or out of the 32-bit space for the topmost line).
    assign mem_req_o  = (state_q != S_IDLE);
    assign mem_addr_o = {fill_tag_q, cnt_q, 2'b00};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            line_valid_q <= 1'b0;
            cnt_q        <= '0;
            fill_tag_q   <= '0;
            tag_q        <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (stall_req_o) begin
                        state_q      <= S_FILL;
                        fill_tag_q   <= pc_i[31:OFF];
                        cnt_q        <= '0;
                        line_valid_q <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (flush_i) begin
                        // An ack arriving with the flush is consumed here,
                        // otherwise the owed ack is absorbed in S_ABORT.
                        state_q <= mem_ack_i ? S_IDLE : S_ABORT;
                    end else if (mem_ack_i) begin
                        cnt_q <= cnt_q + IDX_W'(1);
                        if (cnt_q == LAST_IDX) begin
                            tag_q        <= fill_tag_q;
                            line_valid_q <= 1'b1;
                            state_q      <= S_IDLE;
                        end
                    end
                end
                S_ABORT: begin
                    if (mem_ack_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Line storage needs no reset; line_valid_q guards every read.
    always_ff @(posedge clk_i) begin
        if (!rst_i && state_q == S_FILL && !flush_i && mem_ack_i) begin
            line_q[cnt_q] <= mem_rdata_i;
        end
    end

endmodule

// File: tb/tb_inst_fetch_resp.sv
module tb_inst_fetch_resp;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] pc_i = 32'h0;
    logic        ce_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        misaligned_o;
    logic        stall_req_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;

    int pass_cnt = 0;
    int check_cnt = 0;
    int mem_wait = 0;
    int waited = 0;
    logic [31:0] exp_addr [$];

    inst_fetch_resp #(.LINE_WORDS(4), .NOP_INST(NOP)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i), .ce_i(ce_i),
        .flush_i(flush_i), .inst_o(inst_o), .inst_valid_o(inst_valid_o),
        .misaligned_o(misaligned_o), .stall_req_o(stall_req_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a >> 2) + 32'h60;
    endfunction

    // Backing memory: acks after mem_wait idle cycles per word; every cycle a
    // request is up, the address is compared with the scoreboard head.
    always @(posedge clk_i) begin
        #1;
        if (rst_i || !mem_req_o) begin
            mem_ack_i = 1'b0;
            waited = 0;
        end else begin
            check_cnt++;
            if (exp_addr.size() == 0)
                $display("FAIL mem_addr unexpected request addr=%h", mem_addr_o);
            else if (mem_addr_o !== exp_addr[0])
                $display("FAIL mem_addr got=%h exp=%h", mem_addr_o, exp_addr[0]);
            else
                pass_cnt++;
            if (waited >= mem_wait) begin
                mem_ack_i = 1'b1;
                mem_rdata_i = mem_data(mem_addr_o);
                waited = 0;
                if (exp_addr.size() != 0) void'(exp_addr.pop_front());
            end else begin
                mem_ack_i = 1'b0;
                waited++;
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        ce_i = 1'b0;
        step();
        step();
        check_cnt++;
        if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0 || inst_valid_o !== 1'b0 ||
            inst_o !== NOP || stall_req_o !== 1'b0 || misaligned_o !== 1'b0)
            $display("FAIL reset req=%b addr=%h valid=%b inst=%h stall=%b mis=%b exp 0/0/0/%h/0/0",
                     mem_req_o, mem_addr_o, inst_valid_o, inst_o, stall_req_o, misaligned_o, NOP);
        else pass_cnt++;
        ce_i = 1'b1;
        pc_i = 32'h100;
        #1;
        check_cnt++;
        if (stall_req_o !== 1'b1) $display("FAIL reset_stall got=%b exp=1", stall_req_o);
        else pass_cnt++;
        ce_i = 1'b0;
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_cold_miss();
        int n;
        mem_wait = 0;
        for (int i = 0; i < 4; i++) exp_addr.push_back(32'h100 + 32'(4 * i));
        ce_i = 1'b1;
        pc_i = 32'h100;
        #1;
        n = 0;
        while (stall_req_o && n < 60) begin n++; step(); end
        check_cnt++;
        if (n !== 5) $display("FAIL cold_stall_cycles got=%0d exp=5", n);
        else pass_cnt++;
        check_cnt++;
        if (inst_o !== 32'hA0 || inst_valid_o !== 1'b1 || exp_addr.size() != 0)
            $display("FAIL cold_hit inst=%h valid=%b left=%0d exp a0/1/0",
                     inst_o, inst_valid_o, exp_addr.size());
        else pass_cnt++;
    endtask

    task automatic test_seq_hits();
        logic [31:0] exp_inst [$];
        for (int i = 1; i < 4; i++) exp_inst.push_back(32'hA0 + 32'(i));
        for (int i = 1; i < 4; i++) begin
            step();
            pc_i = 32'h100 + 32'(4 * i);
            #1;
            check_cnt++;
            if (inst_o !== exp_inst[0] || inst_valid_o !== 1'b1 ||
                stall_req_o !== 1'b0 || mem_req_o !== 1'b0)
                $display("FAIL seq_hit pc=%h inst=%h valid=%b stall=%b req=%b exp %h/1/0/0",
                         pc_i, inst_o, inst_valid_o, stall_req_o, mem_req_o, exp_inst[0]);
            else pass_cnt++;
            void'(exp_inst.pop_front());
        end
        step();
    endtask

    task automatic test_wait_states();
        int n;
        mem_wait = 2;
        for (int i = 0; i < 4; i++) exp_addr.push_back(32'h200 + 32'(4 * i));
        pc_i = 32'h200;
        #1;
        n = 0;
        while (stall_req_o && n < 60) begin n++; step(); end
        check_cnt++;
        if (n !== 13) $display("FAIL wait_stall_cycles got=%0d exp=13", n);
        else pass_cnt++;
        check_cnt++;
        if (inst_o !== mem_data(32'h200) || inst_valid_o !== 1'b1)
            $display("FAIL wait_hit inst=%h valid=%b exp %h/1", inst_o, inst_valid_o, mem_data(32'h200));
        else pass_cnt++;
    endtask

    task automatic test_top_line();
        int n;
        mem_wait = 0;
        for (int i = 0; i < 4; i++) exp_addr.push_back(32'hFFFF_FFF0 + 32'(4 * i));
        pc_i = 32'hFFFF_FFFC;
        #1;
        n = 0;
        while (stall_req_o && n < 60) begin n++; step(); end
        check_cnt++;
        if (inst_o !== mem_data(32'hFFFF_FFFC) || inst_valid_o !== 1'b1 || n !== 5)
            $display("FAIL top_line inst=%h valid=%b cycles=%0d exp %h/1/5",
                     inst_o, inst_valid_o, n, mem_data(32'hFFFF_FFFC));
        else pass_cnt++;
    endtask

    task automatic test_flush_mid_fill();
        int n;
        mem_wait = 2;
        exp_addr.push_back(32'h300);
        exp_addr.push_back(32'h304);
        pc_i = 32'h300;
        n = 0;
        while (mem_addr_o !== 32'h304 && n < 40) begin n++; step(); end
        check_cnt++;
        if (mem_addr_o !== 32'h304 || mem_req_o !== 1'b1)
            $display("FAIL flush_reach_word1 addr=%h req=%b exp 304/1", mem_addr_o, mem_req_o);
        else pass_cnt++;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        #1;
        check_cnt++;
        if (stall_req_o !== 1'b1 || inst_valid_o !== 1'b0)
            $display("FAIL abort_stall stall=%b valid=%b exp 1/0", stall_req_o, inst_valid_o);
        else pass_cnt++;
        n = 0;
        while (mem_req_o && n < 40) begin n++; step(); end
        check_cnt++;
        if (mem_req_o !== 1'b0 || exp_addr.size() != 0 || n !== 2)
            $display("FAIL abort_drop req=%b left=%0d cycles=%0d exp 0/0/2",
                     mem_req_o, exp_addr.size(), n);
        else pass_cnt++;
        check_cnt++;
        if (stall_req_o !== 1'b1 || inst_valid_o !== 1'b0)
            $display("FAIL refetch_after_flush stall=%b valid=%b exp 1/0", stall_req_o, inst_valid_o);
        else pass_cnt++;
        ce_i = 1'b0;
        step();
    endtask

    task automatic test_misaligned();
        ce_i = 1'b1;
        pc_i = 32'h102;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_cnt++;
            if (misaligned_o !== 1'b1 || inst_valid_o !== 1'b0 ||
                stall_req_o !== 1'b0 || mem_req_o !== 1'b0)
                $display("FAIL misaligned mis=%b valid=%b stall=%b req=%b exp 1/0/0/0",
                         misaligned_o, inst_valid_o, stall_req_o, mem_req_o);
            else pass_cnt++;
            step();
        end
    endtask

    task automatic test_flush_idle_and_reset_mid_fill();
        int n;
        mem_wait = 0;
        for (int i = 0; i < 4; i++) exp_addr.push_back(32'h100 + 32'(4 * i));
        pc_i = 32'h100;
        n = 0;
        #1;
        while (stall_req_o && n < 60) begin n++; step(); end
        pc_i = 32'h104;
        flush_i = 1'b1;
        #1;
        check_cnt++;
        if (inst_o !== 32'hA1 || inst_valid_o !== 1'b1 || stall_req_o !== 1'b0)
            $display("FAIL flush_idle_hit inst=%h valid=%b stall=%b exp a1/1/0",
                     inst_o, inst_valid_o, stall_req_o);
        else pass_cnt++;
        step();
        flush_i = 1'b0;
        mem_wait = 2;
        for (int i = 0; i < 4; i++) exp_addr.push_back(32'h400 + 32'(4 * i));
        pc_i = 32'h400;
        n = 0;
        while (mem_addr_o !== 32'h408 && n < 60) begin n++; step(); end
        rst_i = 1'b1;
        step();
        check_cnt++;
        if (mem_req_o !== 1'b0 || inst_valid_o !== 1'b0)
            $display("FAIL reset_mid_fill req=%b valid=%b exp 0/0", mem_req_o, inst_valid_o);
        else pass_cnt++;
        exp_addr.delete();
        ce_i = 1'b0;
        rst_i = 1'b0;
        step();
        ce_i = 1'b1;
        pc_i = 32'h100;
        #1;
        check_cnt++;
        if (stall_req_o !== 1'b1 || inst_valid_o !== 1'b0)
            $display("FAIL old_line_after_reset stall=%b valid=%b exp 1/0", stall_req_o, inst_valid_o);
        else pass_cnt++;
        ce_i = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_seq_hits();
        test_wait_states();
        test_top_line();
        test_flush_mid_fill();
        test_misaligned();
        test_flush_idle_and_reset_mid_fill();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
